// File: rtl/prog_loader_pkg.sv
// Shared widths, state encoding and limits for the program loader.
// The state encoding matches the PL_HDR0..PL_ERR values used on the host side.
package prog_loader_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 10;
  localparam int LEN_WIDTH      = 16;

  localparam int unsigned MAX_WORDS = 1 << MEM_ADDR_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    PL_HDR0 = 3'd0,
    PL_HDR1 = 3'd1,
    PL_LOAD = 3'd2,
    PL_RUN  = 3'd3,
    PL_DONE = 3'd4,
    PL_ERR  = 3'd5
  } pl_state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian 8-to-32 assembler: the first byte of a word lands in bits [7:0].
// word_valid_o is combinational and pulses alongside the fourth byte.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [WORD_WIDTH-1:0] word_o
);

  logic [1:0]            idx_q;
  logic [WORD_WIDTH-9:0] low_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      low_q <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
    end else if (byte_valid_i) begin
      idx_q <= idx_q + 2'd1;
      case (idx_q)
        2'd0:    low_q[7:0]   <= byte_i;
        2'd1:    low_q[15:8]  <= byte_i;
        2'd2:    low_q[23:16] <= byte_i;
        default: ;
      endcase
    end
  end

  assign word_valid_o = byte_valid_i && !clear_i && (idx_q == 2'd3);
  assign word_o       = {byte_i, low_q};

endmodule

// File: rtl/prog_loader.sv
// Host program loader: receives a length header and image, writes instruction
// memory with the core held in reset, runs the core and returns its result.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      imem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] imem_waddr,
  output logic [WORD_WIDTH-1:0]     imem_wdata,
  output logic                      core_rst,
  input  logic                      core_halt,
  input  logic [WORD_WIDTH-1:0]     core_final_data,
  output logic [WORD_WIDTH-1:0]     res_data,
  output logic [31:0]               res_cycles,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      err
);

  pl_state_e                 state_q;
  logic [7:0]                len_lo_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [MEM_ADDR_WIDTH-1:0] widx_q;
  logic                      load_done_q;
  logic                      halt_q;
  logic                      imem_wen_q;
  logic [MEM_ADDR_WIDTH-1:0] imem_waddr_q;
  logic [WORD_WIDTH-1:0]     imem_wdata_q;
  logic                      core_rst_q;
  logic [WORD_WIDTH-1:0]     res_data_q;
  logic [31:0]               res_cycles_q;
  logic [31:0]               res_cycles_d;
  logic                      res_valid_q;
  logic                      err_q;

  logic                      accept;
  logic [LEN_WIDTH-1:0]      hdr_len;
  logic                      hdr_bad;
  logic                      last_word;
  logic                      word_valid;
  logic [WORD_WIDTH-1:0]     word;

  assign in_ready  = (state_q == PL_HDR0) || (state_q == PL_HDR1) || (state_q == PL_LOAD);
  assign accept    = in_valid && in_ready;
  assign hdr_len   = {in_data, len_lo_q};
  assign hdr_bad   = (hdr_len == '0) || (32'(hdr_len) > MAX_WORDS);
  assign last_word = ({{(LEN_WIDTH-MEM_ADDR_WIDTH){1'b0}}, widx_q} == (len_q - LEN_ONE));

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    res_cycles_d = res_cycles_q;
    if (res_cycles_q != '1) res_cycles_d = res_cycles_q + 32'd1;
  end

  // The packer is held clear outside LOAD so a stray byte never leaks into the next image.
  prog_loader_byte_packer u_byte_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      ((state_q != PL_LOAD) || load_done_q),
    .byte_valid_i (accept && (state_q == PL_LOAD)),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halt_q <= 1'b1;
    else     halt_q <= core_halt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PL_HDR0;
      len_lo_q     <= '0;
      len_q        <= '0;
      widx_q       <= '0;
      load_done_q  <= 1'b0;
      imem_wen_q   <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      res_data_q   <= '0;
      res_cycles_q <= '0;
      res_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_wen_q <= 1'b0;
      unique case (state_q)
        PL_HDR0: begin
          if (accept) begin
            len_lo_q <= in_data;
            state_q  <= PL_HDR1;
          end
        end
        PL_HDR1: begin
          if (accept) begin
            len_q  <= hdr_len;
            widx_q <= '0;
            if (hdr_bad) begin
              err_q   <= 1'b1;
              state_q <= PL_ERR;
            end else begin
              state_q <= PL_LOAD;
            end
          end
        end
        PL_LOAD: begin
          // Core reset is released one cycle after the final write strobe.
          if (load_done_q) begin
            load_done_q  <= 1'b0;
            core_rst_q   <= 1'b0;
            res_cycles_q <= '0;
            state_q      <= PL_RUN;
          end else if (word_valid) begin
            imem_wen_q   <= 1'b1;
            imem_waddr_q <= widx_q;
            imem_wdata_q <= word;
            widx_q       <= widx_q + MEM_ADDR_WIDTH'(1);
            if (last_word) load_done_q <= 1'b1;
          end
        end
        PL_RUN: begin
          if (!halt_q) begin
            res_data_q  <= core_final_data;
            res_valid_q <= 1'b1;
            state_q     <= PL_DONE;
          end else begin
            res_cycles_q <= res_cycles_d;
          end
        end
        PL_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            core_rst_q  <= 1'b1;
            state_q     <= PL_HDR0;
          end
        end
        PL_ERR:  ;
        default: begin
          err_q   <= 1'b1;
          state_q <= PL_ERR;
        end
      endcase
    end
  end

  assign imem_wen   = imem_wen_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign res_data   = res_data_q;
  assign res_cycles = res_cycles_q;
  assign res_valid  = res_valid_q;
  assign err        = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Host-side program loader and run controller for the pipelined RISC-V core. It accepts a byte stream from the host: a 16-bit word-count header, then the program image as little-endian 32-bit words. It writes the image into instruction memory while holding the core in reset, then releases the core. When the core halts, it returns the core's final data word and the run's cycle count to the host through a valid/ready handshake.

## Interface
- `WORD_WIDTH`, 32, instruction/data word width (`WORD_WIDTH` from constants.vh)
- `MEM_ADDR_WIDTH`, 10, instruction memory word-address width (`MEM_ADDR_WIDTH` from constants.vh)
- `LEN_WIDTH`, 16, header word-count width

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  host byte.
- `in_valid`  in  1  host byte valid.
- `in_ready`  out  1  loader accepts a byte; transfer occurs when `in_valid && in_ready`.
- `imem_wen`  out  1  instruction memory write strobe, one cycle per word.
- `imem_waddr`  out  MEM_ADDR_WIDTH  word address.
- `imem_wdata`  out  WORD_WIDTH  word data.
- `core_rst`  out  1  reset to the core, active-high.
- `core_halt`  in  1  core halt output; active-low (low = core has halted).
- `core_final_data`  in  WORD_WIDTH  core final_data output.
- `res_data`  out  WORD_WIDTH  captured final data.
- `res_cycles`  out  32  number of RUN cycles, saturating at 0xFFFFFFFF.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  host accepts the result.
- `err`  out  1  header rejected; sticky until `rst`.

## Operation
- The FSM has six states: HDR0, HDR1, LOAD, RUN, DONE, ERR.
- HDR0: accept the low byte of the length. Go to HDR1.
- HDR1: accept the high byte of the length.
  - If length == 0 or length > 2**MEM_ADDR_WIDTH, go to ERR.
  - Otherwise go to LOAD with word index 0 and byte index 0.
- LOAD: accept payload bytes. Byte k of a word goes to bits [8k+7:8k], so the first byte is the LSB.
  - On the 4th byte, `imem_wen` pulses with `imem_waddr` = word index.
  - The word index increments and the byte index wraps to 0.
  - After word (length-1) is written, go to RUN.
- RUN: `core_rst` is low. `res_cycles` counts every cycle spent in RUN. `core_halt` is registered once inside the loader.
  - When the registered halt is low, capture `core_final_data` into `res_data`, freeze `res_cycles`, and go to DONE.
- DONE: `res_valid` is high and `core_rst` stays low, so core state is preserved.
  - On `res_valid && res_ready`, go to HDR0 and reassert `core_rst`.
- ERR: `err` is high, `in_ready` is low, `core_rst` is high. Only `rst` exits this state.
- `in_ready` is decoded combinationally from state: it is 1 in HDR0, HDR1 and LOAD, and 0 otherwise. `in_valid` gaps of any length are tolerated.
- Reset mid-operation returns to HDR0 immediately. Partially written instruction memory is not scrubbed.

## Timing
- Reset values:
  - state HDR0, so `in_ready`=1
  - `imem_wen`=0, `imem_waddr`=0, `imem_wdata`=0
  - `core_rst`=1
  - `res_data`=0, `res_cycles`=0, `res_valid`=0
  - `err`=0
- `imem_*` outputs are registered. The write strobe is high in the cycle after the 4th byte is accepted.
- `core_rst` is registered. It falls in the cycle after the last `imem_wen` pulse, and the state enters RUN on the same edge.
- Halt latency: `core_halt` low in cycle n gives the registered halt in n+1; `res_valid` is high from n+2.
- `res_cycles` counts RUN cycles inclusive of the cycle the registered halt is sampled.
- `res_valid`, `res_data` and `res_cycles` stay stable while `res_ready` is low.
- The handshake edge clears `res_valid` on the next cycle.

## Structure
- constants.vh carries the state encodings (`PL_HDR0`…`PL_ERR`, 3 bits) and `LEN_WIDTH`.
- One sub-module, `byte_packer`, holds the 8-to-32 little-endian shift/assemble logic and the 2-bit byte counter. Its output is a `word_valid` pulse with the assembled word.
- The FSM, address counter, cycle counter and result registers live in `prog_loader`.

## Test plan
- Header 02 00, bytes 13 00 00 00 93 00 50 00:
  - writes addr0=0x00000013 and addr1=0x00500093
  - `core_rst` falls 1 cycle after the second write
- Header 00 00 -> `err`=1 and `in_ready`=0 from the next cycle; no `imem_wen` occurs. Recovery requires `rst`.
- Header 01 04 (1025) with MEM_ADDR_WIDTH=10 -> `err`=1. Header 00 04 (1024) -> loads 1024 words, last `imem_waddr`=0x3FF.
- Random `in_valid` gaps of 0–5 cycles over a 4-word load -> identical writes at identical addresses in order, with no extra strobes.
- Load 1 word, drive `core_halt` low after 7 RUN cycles with `core_final_data`=0xDEADBEEF, and hold `res_ready`=0 for 3 cycles:
  - `res_valid` is held, `res_data`=0xDEADBEEF, `res_cycles`=8
  - on handshake, `core_rst`=1 and state returns to HDR0
- Assert `rst` after the 6th payload byte of a 2-word load -> all outputs at reset values; a fresh 1-word load then writes addr0 correctly.
